// File: rtl/page_table_walker.sv
// Two-level page table walker between the TLB miss path and the PTE memory.
// Walks L1 then L2 over a valid/ready read port and reports the leaf PPN and
// flags, or a fault code. One walk in flight; outputs decoded from state.
// Optional feature macro: PTW_L1_CACHE_EN adds a one-entry L1 pointer cache
// that lets a walk skip the L1 read when vaddr[31:22] hits.
module page_table_walker #(
    parameter logic [31:0] ROOT_PT_BASE = 32'h0000_0400,
    parameter logic [31:0] PTE_PTR_MASK = 32'hFFFF_FC00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        walk_req_valid_i,
    output logic        walk_req_ready_o,
    input  logic [31:0] walk_vaddr_i,
    input  logic        walk_is_write_i,
    output logic        walk_resp_valid_o,
    input  logic        walk_resp_ready_i,
    output logic [19:0] walk_ppn_o,
    output logic [3:0]  walk_flags_o,
    output logic [1:0]  walk_fault_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_addr_o,
    input  logic        mem_resp_valid_i,
    output logic        mem_resp_ready_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L2_REQ  = 3'd3,
        L2_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_INVALID = 2'd1;
    localparam logic [1:0] FAULT_MALFORM = 2'd2;
    localparam logic [1:0] FAULT_PERM    = 2'd3;

    state_t      state_reg, state_next;
    logic [9:0]  vpn0_reg, vpn0_next;
    logic        is_write_reg, is_write_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [19:0] ppn_reg, ppn_next;
    logic [3:0]  flags_reg, flags_next;
    logic [1:0]  fault_reg, fault_next;

    // Page offset bits never take part in a walk.
    logic unused_vaddr_bits;
    assign unused_vaddr_bits = ^walk_vaddr_i[11:0];

    // PTE decode of the word currently on the memory response bus.
    logic        pte_valid;
    logic        pte_leaf;
    logic        pte_perm_ok;
    logic [31:0] l1_addr;
    logic [31:0] l2_addr;

    assign pte_valid   = mem_data_i[0];
    assign pte_leaf    = mem_data_i[1] | mem_data_i[2];
    assign pte_perm_ok = is_write_reg ? mem_data_i[2] : mem_data_i[1];
    assign l1_addr     = ROOT_PT_BASE + {20'd0, walk_vaddr_i[31:22], 2'b00};
    assign l2_addr     = (mem_data_i & PTE_PTR_MASK) + {20'd0, vpn0_reg, 2'b00};

`ifdef PTW_L1_CACHE_EN
    logic        cache_valid_reg, cache_valid_next;
    logic [9:0]  cache_vpn1_reg, cache_vpn1_next;
    logic [31:0] cache_pte_reg, cache_pte_next;
    logic [9:0]  vpn1_reg, vpn1_next;
    logic        cache_hit;
    logic [31:0] cache_l2_addr;

    assign cache_hit     = cache_valid_reg && (cache_vpn1_reg == walk_vaddr_i[31:22]);
    assign cache_l2_addr = (cache_pte_reg & PTE_PTR_MASK) + {20'd0, walk_vaddr_i[21:12], 2'b00};

    // Cached L1 pointer entry; only a reset drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_valid_reg <= 1'b0;
            cache_vpn1_reg  <= '0;
            cache_pte_reg   <= '0;
            vpn1_reg        <= '0;
        end else begin
            cache_valid_reg <= cache_valid_next;
            cache_vpn1_reg  <= cache_vpn1_next;
            cache_pte_reg   <= cache_pte_next;
            vpn1_reg        <= vpn1_next;
        end
    end
`endif

    // State and walk datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            vpn0_reg     <= '0;
            is_write_reg <= 1'b0;
            mem_addr_reg <= '0;
            ppn_reg      <= '0;
            flags_reg    <= '0;
            fault_reg    <= FAULT_NONE;
        end else begin
            state_reg    <= state_next;
            vpn0_reg     <= vpn0_next;
            is_write_reg <= is_write_next;
            mem_addr_reg <= mem_addr_next;
            ppn_reg      <= ppn_next;
            flags_reg    <= flags_next;
            fault_reg    <= fault_next;
        end
    end

    // Next-state and datapath updates for each walk step.
    always_comb begin
        state_next    = state_reg;
        vpn0_next     = vpn0_reg;
        is_write_next = is_write_reg;
        mem_addr_next = mem_addr_reg;
        ppn_next      = ppn_reg;
        flags_next    = flags_reg;
        fault_next    = fault_reg;
`ifdef PTW_L1_CACHE_EN
        cache_valid_next = cache_valid_reg;
        cache_vpn1_next  = cache_vpn1_reg;
        cache_pte_next   = cache_pte_reg;
        vpn1_next        = vpn1_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (walk_req_valid_i) begin
                    vpn0_next     = walk_vaddr_i[21:12];
                    is_write_next = walk_is_write_i;
`ifdef PTW_L1_CACHE_EN
                    vpn1_next = walk_vaddr_i[31:22];
                    if (cache_hit) begin
                        mem_addr_next = cache_l2_addr;
                        state_next    = L2_REQ;
                    end else begin
                        mem_addr_next = l1_addr;
                        state_next    = L1_REQ;
                    end
`else
                    mem_addr_next = l1_addr;
                    state_next    = L1_REQ;
`endif
                end
            end
            L1_REQ: begin
                if (mem_req_ready_i) begin
                    state_next = L1_WAIT;
                end
            end
            L1_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (!pte_valid || pte_leaf) begin
                        // Superpages are not supported, so an L1 leaf is malformed.
                        ppn_next   = mem_data_i[31:12];
                        flags_next = mem_data_i[3:0];
                        fault_next = pte_valid ? FAULT_MALFORM : FAULT_INVALID;
                        state_next = RESP;
                    end else begin
                        mem_addr_next = l2_addr;
                        state_next    = L2_REQ;
`ifdef PTW_L1_CACHE_EN
                        cache_valid_next = 1'b1;
                        cache_vpn1_next  = vpn1_reg;
                        cache_pte_next   = mem_data_i;
`endif
                    end
                end
            end
            L2_REQ: begin
                if (mem_req_ready_i) begin
                    state_next = L2_WAIT;
                end
            end
            L2_WAIT: begin
                if (mem_resp_valid_i) begin
                    ppn_next   = mem_data_i[31:12];
                    flags_next = mem_data_i[3:0];
                    state_next = RESP;
                    if (!pte_valid) begin
                        fault_next = FAULT_INVALID;
                    end else if (!pte_leaf) begin
                        fault_next = FAULT_MALFORM;
                    end else if (!pte_perm_ok) begin
                        fault_next = FAULT_PERM;
                    end else begin
                        fault_next = FAULT_NONE;
                    end
                end
            end
            RESP: begin
                if (walk_resp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs are a pure function of the current state.
    assign walk_req_ready_o  = (state_reg == IDLE);
    assign mem_req_valid_o   = (state_reg == L1_REQ) || (state_reg == L2_REQ);
    assign mem_resp_ready_o  = (state_reg == L1_WAIT) || (state_reg == L2_WAIT);
    assign walk_resp_valid_o = (state_reg == RESP);
    assign mem_addr_o        = mem_addr_reg;
    assign walk_ppn_o        = ppn_reg;
    assign walk_flags_o      = flags_reg;
    assign walk_fault_o      = fault_reg;

endmodule

// File: doc/page_table_walker.md
Name: page_table_walker

Overview:
- Two-level hardware page table walker that sits directly upstream of the word-addressed memory block.
- Accepts a translation miss from the TLB and issues PTE reads over the memory valid/ready request/response handshake.
- Returns the leaf PPN and flags, or a fault code, to the TLB.
- One walk in flight at a time; Moore-style FSM.

Parameters:
- ROOT_PT_BASE, 32'h0000_0400, byte address of the root (L1) page table.
- PTE_PTR_MASK, 32'hFFFF_FC00, mask applied to a pointer PTE to form the L2 table base; tables are 1 KB aligned.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- walk_req_valid_i  in  1  TLB miss request valid.
- walk_req_ready_o  out  1  high only in IDLE.
- walk_vaddr_i  in  32  virtual address; bits [11:0] are ignored.
- walk_is_write_i  in  1  1 = store access, 0 = load access.
- walk_resp_valid_o  out  1  walk result valid.
- walk_resp_ready_i  in  1  TLB accepts the result.
- walk_ppn_o  out  20  leaf PTE bits [31:12].
- walk_flags_o  out  4  leaf PTE bits [3:0]: {X, W, R, V}.
- walk_fault_o  out  2  0 = ok, 1 = invalid (V=0), 2 = malformed, 3 = permission.
- mem_req_valid_o  out  1  PTE read request.
- mem_req_ready_i  in  1  memory ready.
- mem_addr_o  out  32  PTE byte address, word aligned.
- mem_resp_valid_i  in  1  memory data valid.
- mem_resp_ready_o  out  1  walker accepts the data.
- mem_data_i  in  32  PTE read data.

Behaviour:
- Reset (asynchronous): state = IDLE. All valid and ready outputs are 0 except walk_req_ready_o = 1. walk_ppn_o, walk_flags_o, walk_fault_o, mem_addr_o = 0. The latched vaddr and write bit clear.
- Reset mid-walk: FSM returns to IDLE immediately. Any memory response arriving afterwards is not consumed, because mem_resp_ready_o = 0 in IDLE.
- States: IDLE, L1_REQ, L1_WAIT, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - On walk_req_valid_i, latch walk_vaddr_i and walk_is_write_i.
  - Set mem_addr_o = ROOT_PT_BASE + {vaddr[31:22], 2'b00}; go to L1_REQ.
- L1_REQ / L2_REQ:
  - mem_req_valid_o = 1 and mem_addr_o is held stable until the cycle where mem_req_ready_i = 1.
  - In that cycle, go to the matching *_WAIT state.
- L1_WAIT / L2_WAIT:
  - mem_resp_ready_o = 1; the state waits for mem_resp_valid_i. The number of wait cycles is unbounded.
- PTE decode: leaf = pte[1] | pte[2].
- L1 response:
  - V = 0 → fault 1.
  - Leaf → fault 2; superpages are unsupported.
  - Otherwise, mem_addr_o = (pte & PTE_PTR_MASK) + {vaddr[21:12], 2'b00}; go to L2_REQ.
- L2 response:
  - V = 0 → fault 1.
  - Not a leaf → fault 2.
  - Write access with W = 0, or read access with R = 0 → fault 3.
  - Otherwise → fault 0.
- Any fault or leaf result: load walk_ppn_o = pte[31:12] and walk_flags_o = pte[3:0], then go to RESP.
  - For an L1 fault these outputs carry the L1 PTE.
  - No L2 request is issued after an L1 fault.
- RESP:
  - walk_resp_valid_o = 1; the result is held stable until walk_resp_ready_i.
  - When the handshake completes, go to IDLE; walk_req_ready_o = 1 on the next cycle.
- Latency: a miss is accepted no earlier than the cycle after the previous result handshake. Walker overhead is 1 cycle per state transition, excluding memory wait cycles.
- Arithmetic: all address adds are 32-bit and wrap; no overflow check.
- Misaligned addresses cannot occur, since the low 2 bits are always 00.

Optional Feature:
- Macro: PTW_L1_CACHE_EN.
- When defined:
  - The walker holds a one-entry register {valid, vpn1[9:0], pointer PTE}.
  - It is filled only on a valid, non-leaf L1 response.
  - In IDLE, a request whose vaddr[31:22] matches a valid entry skips L1: it goes straight to L2_REQ using the cached pointer, saving one full memory round trip.
  - Reset clears the valid bit.
- When undefined: every walk performs both memory reads, and the register is absent.

Test Plan:
- Read vaddr 0x0000_1000; memory has [0x400] = 0x0000_0801 and [0x804] = 0x1100_000F → requests go to 0x400 then 0x804; response ppn = 0x11000, flags = 0xF, fault = 0.
- Read vaddr 0x0040_0000; [0x404] = 0x1234_0000 → single request to 0x404, fault = 1, no L2 request issued.
- Write vaddr 0x0000_2000; [0x808] = 0x1200_0003 → fault = 3, ppn = 0x12000, flags = 0x3. The same vaddr as a read → fault = 0.
- Read vaddr 0x0000_3000; [0x80C] = 0 → fault = 1 after two reads. Separately, an L1 entry of 0x0000_0803 (a leaf at L1) → fault = 2.
- Backpressure and reset:
  - Hold walk_resp_ready_i = 0 for 5 cycles → result outputs stay stable and walk_req_ready_o stays 0.
  - Assert rst while in L2_WAIT → all outputs take reset values in the same cycle, and the next walk completes correctly.
- With PTW_L1_CACHE_EN defined: back-to-back reads of 0x0000_1000 then 0x0001_8000 → the second walk issues only the request to 0x860 and returns ppn = 0x12345.
